// File: rtl/i2c_master_tx_if.sv
// Request/response bundle between the AV config sequencer and the I2C write master.
interface i2c_master_tx_if;
  logic [6:0] I2C_ADDR;
  logic       I2C_WLEN;
  logic [7:0] I2C_WDATA1;
  logic [7:0] I2C_WDATA2;
  logic       iSTART;
  logic       oEND;
  logic       oACK;

  modport master (output I2C_ADDR, I2C_WLEN, I2C_WDATA1, I2C_WDATA2, iSTART,
                  input  oEND, oACK);
  modport slave  (input  I2C_ADDR, I2C_WLEN, I2C_WDATA1, I2C_WDATA2, iSTART,
                  output oEND, oACK);
endinterface

// File: rtl/i2c_master_tx.sv
// Write-only single-master I2C controller: START, addr+W, 1-2 data bytes, STOP.
// Each bit period is four divider ticks; SCL/SDA are registered off the FSM state.
module i2c_master_tx #(
  parameter int CLK_Freq = 50_000_000,
  parameter int I2C_Freq = 400_000
) (
  input  logic           iCLK,
  input  logic           reset_n,
  i2c_master_tx_if.slave req,
  output logic           I2C_SCL,
  inout  wire            I2C_SDA
);
  localparam int DIV_RAW = CLK_Freq / (4 * I2C_Freq);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ACK0, S_DATA1, S_ACK1, S_DATA2, S_ACK2, S_STOP
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic [1:0]    q;
  logic [2:0]    bit_cnt;
  logic [7:0]    sh;
  logic [6:0]    addr_l;
  logic          wlen_l;
  logic [7:0]    wd1_l, wd2_l;
  logic          start_s1, start_s2;
  logic          nack, end_r, ack_r, scl_r, sda_oe;
  logic          scl_nxt, sda_oe_nxt;
  logic          tick, last_q, start_edge, is_ack, is_byte;

  assign tick       = (state != S_IDLE) && (div_cnt == DW'(DIV - 1));
  assign last_q     = tick && (q == 2'd3);
  assign start_edge = (state == S_IDLE) && start_s1 && !start_s2;
  assign is_ack     = (state == S_ACK0) || (state == S_ACK1) || (state == S_ACK2);
  assign is_byte    = (state == S_ADDR) || (state == S_DATA1) || (state == S_DATA2);

  always_ff @(posedge iCLK or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt  = state;
    scl_nxt    = 1'b1;
    sda_oe_nxt = 1'b0;
    case (state)
      S_IDLE:  if (start_edge) state_nxt = S_START;
      S_START: if (last_q) state_nxt = S_ADDR;
      S_ADDR:  if (last_q && bit_cnt == 3'd7) state_nxt = S_ACK0;
      S_ACK0:  if (last_q) state_nxt = nack ? S_STOP : S_DATA1;
      S_DATA1: if (last_q && bit_cnt == 3'd7) state_nxt = S_ACK1;
      S_ACK1:  if (last_q) state_nxt = (nack || !wlen_l) ? S_STOP : S_DATA2;
      S_DATA2: if (last_q && bit_cnt == 3'd7) state_nxt = S_ACK2;
      S_ACK2:  if (last_q) state_nxt = S_STOP;
      S_STOP:  if (last_q) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // quarter 0: SDA settles with SCL low; quarters 1-2: SCL high; quarter 3: SCL low
    case (state)
      S_START: begin
        sda_oe_nxt = (q != 2'd0);
        scl_nxt    = (q != 2'd3);
      end
      S_ADDR, S_DATA1, S_DATA2: begin
        sda_oe_nxt = !sh[7];
        scl_nxt    = (q == 2'd1) || (q == 2'd2);
      end
      S_ACK0, S_ACK1, S_ACK2: scl_nxt = (q == 2'd1) || (q == 2'd2);
      S_STOP: begin
        sda_oe_nxt = (q != 2'd3);
        scl_nxt    = (q != 2'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or negedge reset_n)
    if (!reset_n) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      div_cnt  <= '0;
      q        <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      addr_l   <= '0;
      wlen_l   <= 1'b0;
      wd1_l    <= '0;
      wd2_l    <= '0;
      nack     <= 1'b0;
      end_r    <= 1'b1;
      ack_r    <= 1'b0;
      scl_r    <= 1'b1;
      sda_oe   <= 1'b0;
    end else begin
      start_s1 <= req.iSTART;
      start_s2 <= start_s1;
      scl_r    <= scl_nxt;
      sda_oe   <= sda_oe_nxt;
      // divider is held clear while idle so every transfer has identical timing
      if (state == S_IDLE || tick) div_cnt <= '0;
      else                         div_cnt <= div_cnt + 1'b1;
      if (state == S_IDLE) q <= '0;
      else if (tick)       q <= q + 2'd1;
      if (start_edge) begin
        addr_l <= req.I2C_ADDR;
        wlen_l <= req.I2C_WLEN;
        wd1_l  <= req.I2C_WDATA1;
        wd2_l  <= req.I2C_WDATA2;
        end_r  <= 1'b0;
        ack_r  <= 1'b0;
      end
      if (tick && q == 2'd2 && is_ack) begin
        nack <= I2C_SDA;
        if (I2C_SDA) ack_r <= 1'b1;
      end
      if (last_q) begin
        if (state_nxt != state) begin
          bit_cnt <= '0;
          case (state_nxt)
            S_ADDR:  sh <= {addr_l, 1'b0};
            S_DATA1: sh <= wd1_l;
            S_DATA2: sh <= wd2_l;
            default: ;
          endcase
        end else if (is_byte) begin
          bit_cnt <= bit_cnt + 3'd1;
          sh      <= {sh[6:0], 1'b0};
        end
        if (state == S_STOP) end_r <= 1'b1;
      end
    end

  assign I2C_SCL  = scl_r;
  assign I2C_SDA  = sda_oe ? 1'b0 : 1'bz;
  assign req.oEND = end_r;
  assign req.oACK = ack_r;
endmodule

// File: tb/tb_i2c_master_tx.sv
// Bench for i2c_master_tx: bus-level slave/decoder plus transfer-level expectations.
module tb_i2c_master_tx;
  localparam int CLK_F  = 4_000_000;
  localparam int I2C_F  = 100_000;
  localparam int DIV    = CLK_F / (4 * I2C_F);
  localparam int BITCYC = 4 * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl;
  wire  sda;
  logic slv_drive = 1'b0;

  pullup (sda);
  assign sda = slv_drive ? 1'b0 : 1'bz;

  i2c_master_tx_if bus();

  i2c_master_tx #(.CLK_Freq(CLK_F), .I2C_Freq(I2C_F)) dut (
    .iCLK    (clk),
    .reset_n (rst_n),
    .req     (bus),
    .I2C_SCL (scl),
    .I2C_SDA (sda)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // bus decoder + ACKing slave
  int         n_start = 0, n_stop = 0, bitn = 0, frame_bytes = 0, nack_idx = -1;
  logic       in_frame = 1'b0;
  logic [7:0] sh = '0;
  logic [7:0] got_q[$];

  always @(negedge sda) if (scl === 1'b1) begin
    n_start++; bitn = 0; frame_bytes = 0; in_frame = 1'b1;
  end
  always @(posedge sda) if (scl === 1'b1) begin
    n_stop++; in_frame = 1'b0;
  end
  always @(posedge scl) if (in_frame) begin
    if (bitn < 8) sh = {sh[6:0], sda};
    else begin got_q.push_back(sh); frame_bytes++; end
    bitn = (bitn == 8) ? 0 : bitn + 1;
  end
  always @(negedge scl) begin
    if (in_frame && bitn == 8) slv_drive = (frame_bytes != nack_idx);
    else                       slv_drive = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_rng(input string tag, input int obs, input int exp, input int tol);
    tests++;
    assert (obs >= exp - tol && obs <= exp + tol) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    end
  endtask

  task automatic wait_oend(input logic lvl, input int lim, output int cyc);
    cyc = 0;
    while (bus.oEND !== lvl && cyc < lim) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // one transfer; expectations come from the byte list and the NACK position only
  task automatic run_xfer(input logic [6:0] a, input logic w, input logic [7:0] d1,
                          input logic [7:0] d2, input int nk, input logic hold);
    logic [7:0] exp_q[$];
    int         nsent, cyc;
    logic       exp_ack;
    exp_q = '{{a, 1'b0}, d1};
    if (w) exp_q.push_back(d2);
    exp_ack = (nk >= 0 && nk < exp_q.size());
    nsent   = exp_ack ? nk + 1 : exp_q.size();
    bus.I2C_ADDR = a; bus.I2C_WLEN = w; bus.I2C_WDATA1 = d1; bus.I2C_WDATA2 = d2;
    nack_idx = nk; got_q.delete(); n_start = 0; n_stop = 0;
    @(posedge clk); #1 bus.iSTART = 1'b1;
    @(posedge clk); #1 check("oend_hold_1st_clk", bus.oEND, 1'b1);
    @(posedge clk); #1 check("oend_fall_2nd_clk", bus.oEND, 1'b0);
    check("oack_cleared_at_start", bus.oACK, 1'b0);
    if (!hold) bus.iSTART = 1'b0;
    // inputs must have been latched, so scramble them mid-transfer
    bus.I2C_ADDR = 7'($urandom); bus.I2C_WLEN = 1'($urandom);
    bus.I2C_WDATA1 = 8'($urandom); bus.I2C_WDATA2 = 8'($urandom);
    wait_oend(1'b1, 3000, cyc);
    check("oend_rise", bus.oEND, 1'b1);
    check_rng("xfer_len", cyc, (2 + 9 * nsent) * BITCYC, 8);
    check("oack", bus.oACK, exp_ack);
    check("n_start", n_start, 1);
    check("n_stop", n_stop, 1);
    check("n_bytes", got_q.size(), nsent);
    for (int i = 0; i < nsent && i < got_q.size(); i++)
      check($sformatf("byte%0d", i), got_q[i], exp_q[i]);
  endtask

  initial begin
    int cyc;
    logic [7:0] seq_q[$];
    bus.iSTART = 1'b0; bus.I2C_ADDR = '0; bus.I2C_WLEN = 1'b0;
    bus.I2C_WDATA1 = '0; bus.I2C_WDATA2 = '0;

    repeat (3) @(posedge clk); #1;
    check("rst_oend", bus.oEND, 1'b1);
    check("rst_oack", bus.oACK, 1'b0);
    check("rst_scl", scl, 1'b1);
    check("rst_sda", sda, 1'b1);
    rst_n = 1'b1;
    repeat (50) @(posedge clk); #1;
    check("idle_oend", bus.oEND, 1'b1);

    run_xfer(7'h39, 1'b1, 8'h41, 8'h10, -1, 1'b0);
    run_xfer(7'h39, 1'b0, 8'h98, 8'h00, -1, 1'b0);

    // address NACK with iSTART left high: must not retrigger
    run_xfer(7'h39, 1'b1, 8'h41, 8'h10, 0, 1'b1);
    repeat (300) @(posedge clk); #1;
    check("held_no_retrig_oend", bus.oEND, 1'b1);
    check("held_no_retrig_starts", n_start, 1);
    check("held_oack_kept", bus.oACK, 1'b1);
    bus.iSTART = 1'b0;
    repeat (5) @(posedge clk);
    run_xfer(7'h1a, 1'b1, 8'h5a, 8'ha5, -1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int nk;
      nk = int'($urandom_range(0, 4)) - 2;
      run_xfer(7'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), nk, 1'b0);
    end

    // reset during DATA1 (DATA1 spans 400..720 clocks after oEND falls)
    bus.I2C_ADDR = 7'h39; bus.I2C_WLEN = 1'b1; bus.I2C_WDATA1 = 8'h00; bus.I2C_WDATA2 = 8'h00;
    nack_idx = -1;
    @(posedge clk); #1 bus.iSTART = 1'b1;
    repeat (2) @(posedge clk); #1 bus.iSTART = 1'b0;
    repeat (500) @(posedge clk); #1;
    check("pre_rst_busy", bus.oEND, 1'b0);
    check("pre_rst_sda_low", sda, 1'b0);
    rst_n = 1'b0; #1;
    check("midrst_scl", scl, 1'b1);
    check("midrst_sda", sda, 1'b1);
    check("midrst_oend", bus.oEND, 1'b1);
    check("midrst_oack", bus.oACK, 1'b0);
    #2 rst_n = 1'b1;
    in_frame = 1'b0; n_start = 0; n_stop = 0;
    repeat (400) @(posedge clk); #1;
    check("postrst_idle_oend", bus.oEND, 1'b1);
    check("postrst_idle_starts", n_start, 0);

    // sequencer-style handshake, three writes
    got_q.delete(); n_start = 0; n_stop = 0; nack_idx = -1;
    for (int k = 0; k < 3; k++) begin
      bus.I2C_ADDR = 7'($urandom); bus.I2C_WLEN = 1'b1;
      bus.I2C_WDATA1 = 8'($urandom); bus.I2C_WDATA2 = 8'($urandom);
      seq_q.push_back({bus.I2C_ADDR, 1'b0});
      seq_q.push_back(bus.I2C_WDATA1);
      seq_q.push_back(bus.I2C_WDATA2);
      @(posedge clk); #1 bus.iSTART = 1'b1;
      wait_oend(1'b0, 20, cyc);
      check("seq_busy", bus.oEND, 1'b0);
      bus.iSTART = 1'b0;
      wait_oend(1'b1, 3000, cyc);
      check("seq_done", bus.oEND, 1'b1);
    end
    repeat (300) @(posedge clk); #1;
    check("seq_starts", n_start, 3);
    check("seq_stops", n_stop, 3);
    check("seq_nbytes", got_q.size(), seq_q.size());
    for (int i = 0; i < seq_q.size() && i < got_q.size(); i++)
      check($sformatf("seq_byte%0d", i), got_q[i], seq_q[i]);
    check("seq_oack", bus.oACK, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/i2c_master_tx.md
Name: i2c_master_tx

Overview:
- Write-only, single-master I2C controller used by the AV configuration sequencer to program HDMI-TX and audio codec registers.
- For each transfer it sends START, the 7-bit slave address with the write bit, then one or two data bytes (sub-address and value), then STOP.
- It reports transfer completion and whether any byte was not acknowledged.
- Bit timing is derived from the system clock by an integer divider.

Parameters:
- CLK_Freq, 50_000_000: system clock frequency in Hz.
- I2C_Freq, 400_000: target SCL frequency in Hz. The AV config instance uses CLK_Freq=24_576_000 and I2C_Freq=20_000.

Ports:
- iCLK  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- I2C_ADDR  in  7  slave address. An 8-bit source is truncated to bits [6:0].
- I2C_WLEN  in  1  0 = one data byte (WDATA1), 1 = two data bytes (WDATA1, then WDATA2).
- I2C_WDATA1  in  8  first data byte (register sub-address).
- I2C_WDATA2  in  8  second data byte (register value).
- iSTART  in  1  transfer request; rising-edge sensitive.
- oEND  out  1  1 = idle / transfer finished; 0 = transfer in progress.
- oACK  out  1  0 = every byte ACKed; 1 = a NACK occurred. Valid while oEND=1.
- I2C_SCL  out  1  SCL, driven push-pull.
- I2C_SDA  inout  1  SDA, open-drain: drives 0 or 'z'. Sampled for ACK.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - oEND=1, oACK=0, I2C_SCL=1, SDA released ('z').
  - Divider cleared; FSM in IDLE; start-edge register cleared.
- Timing:
  - DIV = CLK_Freq/(4*I2C_Freq), integer division, minimum 1.
  - A tick pulses once every DIV iCLK cycles.
  - Each SCL bit period is 4 ticks: SDA changes in quarter 0 with SCL low; SCL rises at quarter 1; SDA is sampled at quarter 2; SCL falls at quarter 3.
- Start:
  - iSTART is registered; a 0->1 edge seen while in IDLE latches I2C_ADDR, I2C_WLEN, I2C_WDATA1 and I2C_WDATA2.
  - On the cycle after the edge is detected: oEND goes to 0 and oACK is cleared to 0.
  - While busy, iSTART is ignored. iSTART held high after completion does not retrigger; a new 0->1 edge is required.
- FSM states: IDLE -> START -> ADDR -> ACK0 -> DATA1 -> ACK1 -> [DATA2 -> ACK2 if WLEN=1] -> STOP -> IDLE.
- START: with SCL high, SDA goes from released to 0; SCL then goes low.
- ADDR: shift out {ADDR[6:0], 1'b0}, MSB first.
- DATA1 / DATA2: shift out the latched byte, MSB first.
- ACK slots:
  - SDA is released; the line is sampled with SCL high.
  - Sampled 1 = NACK: oACK is set to 1 and the FSM jumps directly to STOP (remaining bytes skipped).
- STOP: with SCL low, SDA is driven 0; SCL rises; SDA is then released while SCL is high.
- Completion: after STOP, oEND returns to 1 and the FSM returns to IDLE. oACK holds its value until the next start.
- Transfer length with all bytes ACKed: 1 start + 9 bits per byte (address plus 1 or 2 data bytes) + 1 stop. That is 29 bit periods for WLEN=1 and 20 for WLEN=0.
- Input changes during a transfer have no effect, because the inputs were latched at start.
- Reset mid-transfer aborts immediately: SDA is released, SCL=1, oEND=1.

Test Plan:
- Bench setup: CLK_Freq=4_000_000, I2C_Freq=100_000 (DIV=10); slave model ACKs every byte. Pulse iSTART, ADDR=0x39, WLEN=1, WDATA1=0x41, WDATA2=0x10 -> oEND falls on the 2nd clock after the edge; decoded bytes are 0x72, 0x41, 0x10; START and STOP are legal; oEND rises after 29*40 clocks (±8); oACK=0.
- WLEN=0, WDATA1=0x98 -> only 0x72 and 0x98 are sent; 20 bit periods; oACK=0.
- Slave NACKs the address byte -> STOP follows immediately after ACK0; no data bytes are sent; oEND=1, oACK=1.
- iSTART held high after completion -> no second transfer. Drop iSTART, then raise it again -> a new transfer starts and oACK is cleared.
- Assert reset_n=0 during DATA1 -> the same cycle, SCL=1, SDA='z', oEND=1, oACK=0. After release the block idles until a new iSTART edge.
- Drive the block as the sequencer does: raise iSTART, wait for oEND=0, drop iSTART, wait for oEND=1, over 3 writes -> exactly 3 transfers occur, none missed or duplicated.
